// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared constants, state encoding and helpers for the cpu4 sequencer.
// Holds opcode constants, bus widths, return-stack depth and the FSM state enum.
package cpu4_pkg;

  localparam int unsigned DATA_W          = 4;
  localparam int unsigned ADDR_W          = 4;
  localparam int unsigned MEM_DEPTH       = 16;
  localparam int unsigned RET_STACK_DEPTH = 4;

  localparam logic [DATA_W-1:0] OP_JNZ  = 4'd8;
  localparam logic [DATA_W-1:0] OP_CALL = 4'd11;
  localparam logic [DATA_W-1:0] OP_RET  = 4'd12;
  localparam logic [DATA_W-1:0] OP_HLT  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Sequential successor of a PC; wraps 15 -> 0.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/cpu4_sequencer_if.sv
// cpu4_sequencer_if: program-load, run-control, and command-port signals of the
// cpu4 sequencer.
//   master: drives prog_we/prog_addr/prog_data, start/start_addr, jmp_addr, zf,
//           cmd_ready; observes cmd_valid, cmd, pc, busy, halted, fault.
//   slave : the sequencer side (directions reversed).
interface cpu4_sequencer_if;
  import cpu4_pkg::*;

  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] jmp_addr;
  logic              zf;
  logic              cmd_ready;
  logic              cmd_valid;
  logic [DATA_W-1:0] cmd;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              fault;

  modport master (
    output prog_we, prog_addr, prog_data, start, start_addr, jmp_addr, zf, cmd_ready,
    input  cmd_valid, cmd, pc, busy, halted, fault
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, start_addr, jmp_addr, zf, cmd_ready,
    output cmd_valid, cmd, pc, busy, halted, fault
  );

endinterface

// File: rtl/cpu4_ret_stack.sv
// cpu4_ret_stack: LIFO of return addresses with registered top/full/empty.
// Ports: clk, reset (sync, active-high), clear_i (sync clear), push_i/data_i,
//        pop_i, top_o (current top entry), full_o, empty_o.
// Push is ignored when full, pop is ignored when empty; push wins over pop.
module cpu4_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = !clear_i && push_i && !full_q;
  assign do_pop  = !clear_i && !do_push && pop_i && !empty_q;

  // Next pointer and next top-of-stack (entry below the popped one).
  always_comb begin
    sp_d  = sp_q;
    top_d = top_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (do_push) begin
      sp_d  = sp_q + SP_W'(1);
      top_d = data_i;
    end else if (do_pop) begin
      sp_d = sp_q - SP_W'(1);
      if (sp_q >= SP_W'(2)) begin
        top_d = data_q[IDX_W'(sp_q - SP_W'(2))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      top_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      sp_q    <= sp_d;
      top_q   <= top_d;
      full_q  <= (sp_d == SP_W'(DEPTH));
      empty_q <= (sp_d == '0);
    end
  end

  // Storage needs no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      data_q[IDX_W'(sp_q)] <= data_i;
    end
  end

  assign top_o   = top_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cpu4_sequencer.sv
// cpu4_sequencer: 16x4 program memory plus a fetch/issue sequencer that hands
// opcodes to a datapath over a valid/ready command port.
// Ports: clk, reset (sync, active-high), bus (cpu4_sequencer_if.slave):
//   program load (prog_we/addr/data), run control (start/start_addr),
//   branch inputs (jmp_addr, zf), command port (cmd_valid/cmd/cmd_ready),
//   status (pc, busy, halted, fault).
// Build option: define CPU4_SEQ_CALLSTACK_EN to enable the 4-deep return stack
// (CALL/RET with overflow/underflow FAULT); otherwise CALL/RET advance pc by one
// and fault stays 0.
module cpu4_sequencer
  import cpu4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  cpu4_sequencer_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

`ifdef CPU4_SEQ_CALLSTACK_EN
  logic              stk_clear, stk_push, stk_pop;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_push_data, stk_top;

  cpu4_ret_stack #(
    .DEPTH (RET_STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .clear_i (stk_clear),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (stk_push_data),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );
`endif

  // Program memory: writes locked out while running, contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // State, PC, command and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  // Next state, PC and command; stack control lives here as well.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cmd_d   = cmd_q;
`ifdef CPU4_SEQ_CALLSTACK_EN
    stk_clear     = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = pc_inc(pc_q);
`endif
    case (state_q)
      ST_FETCH: begin
        cmd_d   = mem_q[pc_q];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // cmd_valid is high throughout ISSUE, so ready alone completes the handshake.
        if (bus.cmd_ready) begin
          state_d = ST_FETCH;
          case (cmd_q)
            OP_JNZ: pc_d = bus.zf ? pc_inc(pc_q) : bus.jmp_addr;
            OP_HLT: state_d = ST_HALT;
`ifdef CPU4_SEQ_CALLSTACK_EN
            OP_CALL: begin
              if (stk_full) begin
                state_d = ST_FAULT;
              end else begin
                stk_push = 1'b1;
                pc_d     = bus.jmp_addr;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_d = ST_FAULT;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
`endif
            default: pc_d = pc_inc(pc_q);
          endcase
        end
      end
      default: begin
        // IDLE, HALT and FAULT all accept a new run.
        if (bus.start) begin
          state_d = ST_FETCH;
          pc_d    = bus.start_addr;
`ifdef CPU4_SEQ_CALLSTACK_EN
          stk_clear = 1'b1;
`endif
        end
      end
    endcase
  end

  // Status outputs decoded from the next state so they register with it.
  always_comb begin
    cmd_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_ISSUE);
    halted_d    = (state_d == ST_HALT);
`ifdef CPU4_SEQ_CALLSTACK_EN
    fault_d     = (state_d == ST_FAULT);
`else
    fault_d     = 1'b0;
`endif
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.pc        = pc_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;

endmodule

// File: doc/cpu4_sequencer.md
CPU4_SEQUENCER -- requirements
Module: cpu4_sequencer

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 prog_we  in  1  program memory write strobe; honoured only when busy=0.
REQ-005 prog_addr  in  4  program memory write address.
REQ-006 prog_data  in  4  opcode written at prog_addr.
REQ-007 start  in  1  one-cycle run request; honoured only when busy=0.
REQ-008 start_addr  in  4  first PC on start.
REQ-009 jmp_addr  in  4  target for JNZ (8) and CALL (11).
REQ-010 zf  in  1  zero flag from the 4-bit datapath.
REQ-011 cmd_ready  in  1  datapath accepts cmd this cycle.
REQ-012 cmd_valid  out  1  cmd holds a valid opcode.
REQ-013 cmd  out  4  opcode issued to the datapath command port.
REQ-014 pc  out  4  address of the instruction being fetched or issued.
REQ-015 busy  out  1  high in FETCH or ISSUE.
REQ-016 halted  out  1  high in HALT.
REQ-017 fault  out  1  high in FAULT (return-stack overflow or underflow).

Function
REQ-018 SHALL hold a 16x4 program memory, written on the clk edge when prog_we=1 and busy=0.
REQ-019 SHALL implement states IDLE, FETCH, ISSUE, HALT and FAULT.
REQ-020 IDLE/HALT/FAULT + start: pc<=start_addr, return stack cleared, next state FETCH; start and prog_we are ignored in FETCH and ISSUE.
REQ-021 FETCH: read mem[pc] into cmd (1 cycle), then ISSUE; cmd_valid rises exactly 2 cycles after start is sampled.
REQ-022 ISSUE: cmd_valid=1 and cmd held stable until cmd_valid&&cmd_ready; cmd_valid must not drop before the handshake.
REQ-023 On handshake with opcode 8 (JNZ): pc<=jmp_addr if zf==0, else pc+1; zf is sampled in the handshake cycle.
REQ-024 On handshake with opcode 11 (CALL): push pc+1 and set pc<=jmp_addr; if the stack is full, go to FAULT, pc unchanged and no push.
REQ-025 On handshake with opcode 12 (RET): pop into pc; if the stack is empty, go to FAULT, pc unchanged.
REQ-026 On handshake with opcode 15 (HLT): go to HALT, pc unchanged.
REQ-027 All other opcodes: pc<=pc+1, modulo 16 (15 wraps to 0); state returns to FETCH.
REQ-028 After every non-HLT handshake, cmd_valid SHALL be 0 for exactly one cycle (FETCH).
REQ-029 A CALL return address of 0 (from pc=15) SHALL be legal.

Reset
REQ-030 reset SHALL force: state IDLE, cmd_valid=0, cmd=0, pc=0, busy=0, halted=0, fault=0, stack pointer=0.
REQ-031 reset mid-ISSUE SHALL drop cmd_valid on the next edge with no pc update.
REQ-032 Program memory contents SHALL NOT be affected by reset.

Configuration
REQ-033 CPU4_SEQ_CALLSTACK_EN defined: 4-deep return stack, with REQ-024/025 in force.
REQ-034 CPU4_SEQ_CALLSTACK_EN undefined: CALL and RET are sequenced as plain opcodes (pc+1); FAULT is unreachable; fault is tied to 0.

Structure
REQ-035 Package cpu4_pkg SHALL hold the opcode constants (OP_JNZ=8, OP_CALL=11, OP_RET=12, OP_HLT=15), the state enum and RET_STACK_DEPTH=4.
REQ-036 The return stack SHALL be sub-module cpu4_ret_stack (push/pop/full/empty, sync clear), instantiated only under CPU4_SEQ_CALLSTACK_EN.

Verification
REQ-037 Load mem[0..2]={0,5,15}, start with start_addr=0, cmd_ready=1: cmd sequence 0,5,15, each preceded by a FETCH gap; halted=1; pc=2.
REQ-038 cmd_ready held low 5 cycles in ISSUE: cmd_valid stays 1 and cmd stays stable; pc advances only after ready.
REQ-039 mem[3]=8, jmp_addr=9, zf=0: next pc=9; repeat with zf=1: next pc=4.
REQ-040 mem[14]=11, jmp_addr=2, mem[2]=12: pc sequence 14, 2, 15; a fifth nested CALL -> fault=1 (macro on) or pc+1 (macro off).
REQ-041 mem[15]=4, start_addr=15: after the handshake, pc=0 (wrap).
REQ-042 reset asserted in ISSUE with cmd_ready=0: next cycle cmd_valid=0, pc=0, state IDLE; program memory unchanged on readback run.
